if_prefetch_buffer: RTL and testbench

IF_PREFETCH_BUFFER -- requirements
Module: if_prefetch_buffer

---
 rtl/if_prefetch_buffer.sv | 78 +++++++
 tb/tb_if_prefetch_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_buffer.sv
// if_prefetch_buffer: instruction prefetch FIFO between imem and decode; `IF_FIFO_DEPTH4_EN selects 4 entries instead of 2
module if_prefetch_buffer #(
  parameter logic [31:0] BOOT_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);
`ifdef IF_FIFO_DEPTH4_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 2;
`endif
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD} state_e;
  state_e state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, issued_pc_q;
  logic [31:0] fifo_pc_q [DEPTH];
  logic [31:0] fifo_instr_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0] cnt_q;
  logic fifo_valid, pop, push, room, gnt_acc;
  assign fifo_valid = rst_n && cnt_q != '0;
  assign pop = fifo_valid & instr_ready_i;
  assign room = cnt_q != (AW+1)'(DEPTH) || pop;
  assign gnt_acc = imem_req_o & imem_gnt_i;
  assign push = state_q == S_WAIT && imem_rvalid_i && !redirect_i;
  assign fetch_pc_d = redirect_i ? {redirect_pc_i[31:2], 2'b00} : gnt_acc ? fetch_pc_q + 32'd4 : fetch_pc_q;
  // FSM state register
  always_ff @(posedge clk)
    if (!rst_n) state_q <= S_REQ;
    else state_q <= state_d;
  // next state: a redirect with a response still owed forces DISCARD
  always_comb begin
    state_d = state_q;
    state_d = state_q == S_REQ ? (gnt_acc ? (redirect_i ? S_DISCARD : S_WAIT) : S_REQ) :
              imem_rvalid_i ? S_REQ : redirect_i ? S_DISCARD : state_q;
  end
  // outputs: everything forced to idle values while reset is held
  always_comb begin
    imem_req_o = rst_n && state_q == S_REQ && room;
    imem_addr_o = rst_n ? fetch_pc_q : BOOT_ADDR;
    instr_valid_o = fifo_valid;
    instr_o = fifo_valid ? fifo_instr_q[rd_ptr_q] : 32'h0000_0013;
    instr_pc_o = fifo_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
  end
  // fetch pointer and FIFO bookkeeping; redirect flushes the FIFO
  always_ff @(posedge clk)
    if (!rst_n) begin
      fetch_pc_q <= BOOT_ADDR;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q <= redirect_i ? '0 : rd_ptr_q + AW'(pop);
      wr_ptr_q <= redirect_i ? '0 : wr_ptr_q + AW'(push);
      cnt_q <= redirect_i ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  // remember the address of the granted request and store returned words
  always_ff @(posedge clk) begin
    if (gnt_acc) issued_pc_q <= fetch_pc_q;
    if (push) begin
      fifo_pc_q[wr_ptr_q] <= issued_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
    end
  end
endmodule

// File: tb/tb_if_prefetch_buffer.sv
// tb_if_prefetch_buffer: directed self-checking bench for if_prefetch_buffer
module tb_if_prefetch_buffer;
`ifdef IF_FIFO_DEPTH4_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 2;
`endif
  localparam logic [31:0] BOOT = 32'h8000_0000;
  logic clk = 0, rst_n = 0, redirect_i = 0, imem_gnt_i = 0, imem_rvalid_i = 0, instr_ready_i = 0;
  logic [31:0] redirect_pc_i = 0, imem_rdata_i = 0;
  logic imem_req_o, instr_valid_o;
  logic [31:0] imem_addr_o, instr_o, instr_pc_o;
  int checks = 0, errors = 0;

  if_prefetch_buffer #(.BOOT_ADDR(BOOT)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_one(input logic [31:0] d);
    imem_gnt_i = 1;
    step;
    imem_gnt_i = 0;
    imem_rvalid_i = 1;
    imem_rdata_i = d;
    step;
    imem_rvalid_i = 0;
  endtask

  task automatic test_reset;
    step;
    step;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %h expected 0", imem_req_o); end
    checks++; if (imem_addr_o !== BOOT) begin errors++; $display("FAIL rst_addr: got %h expected %h", imem_addr_o, BOOT); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %h expected 0", instr_valid_o); end
    checks++; if (instr_o !== 32'h13) begin errors++; $display("FAIL rst_instr: got %h expected 00000013", instr_o); end
    checks++; if (instr_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", instr_pc_o); end
  endtask

  task automatic test_first_fetch;
    rst_n = 1;
    imem_gnt_i = 1;
    #1;
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL first_req: got %h expected 1", imem_req_o); end
    checks++; if (imem_addr_o !== BOOT) begin errors++; $display("FAIL first_addr: got %h expected %h", imem_addr_o, BOOT); end
    step;
    imem_gnt_i = 0;
    imem_rvalid_i = 1;
    imem_rdata_i = 32'h93;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL wait_req: got %h expected 0", imem_req_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL wait_valid: got %h expected 0", instr_valid_o); end
    step;
    imem_rvalid_i = 0;
    #1;
    checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL first_valid: got %h expected 1", instr_valid_o); end
    checks++; if (instr_o !== 32'h93) begin errors++; $display("FAIL first_instr: got %h expected 00000093", instr_o); end
    checks++; if (instr_pc_o !== BOOT) begin errors++; $display("FAIL first_pc: got %h expected %h", instr_pc_o, BOOT); end
    checks++; if (imem_addr_o !== BOOT + 4) begin errors++; $display("FAIL next_addr: got %h expected %h", imem_addr_o, BOOT + 4); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < DEPTH - 1; i++) fetch_one(32'h100 + i);
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL full_req: got %h expected 0", imem_req_o); end
    checks++; if (instr_o !== 32'h93) begin errors++; $display("FAIL full_head: got %h expected 00000093", instr_o); end
    step;
    step;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL full_hold: got %h expected 0", imem_req_o); end
    instr_ready_i = 1;
    #1;
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL pop_req: got %h expected 1", imem_req_o); end
    checks++; if (imem_addr_o !== BOOT + 4 * DEPTH) begin errors++; $display("FAIL pop_addr: got %h expected %h", imem_addr_o, BOOT + 4 * DEPTH); end
    step;
    instr_ready_i = 0;
    #1;
    checks++; if (instr_pc_o !== BOOT + 4) begin errors++; $display("FAIL pop_head_pc: got %h expected %h", instr_pc_o, BOOT + 4); end
    checks++; if (instr_o !== 32'h100) begin errors++; $display("FAIL pop_head: got %h expected 00000100", instr_o); end
    checks++; if (imem_addr_o !== BOOT + 4 * DEPTH) begin errors++; $display("FAIL req_stable: got %h expected %h", imem_addr_o, BOOT + 4 * DEPTH); end
    imem_gnt_i = 1;
    step;
    imem_gnt_i = 0;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL one_req: got %h expected 0", imem_req_o); end
  endtask

  task automatic test_redirect_wait;
    redirect_i = 1;
    redirect_pc_i = 32'h8000_0100;
    step;
    redirect_i = 0;
    #1;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %h expected 0", instr_valid_o); end
    checks++; if (instr_o !== 32'h13) begin errors++; $display("FAIL flush_instr: got %h expected 00000013", instr_o); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL discard_req: got %h expected 0", imem_req_o); end
    step;
    imem_rvalid_i = 1;
    imem_rdata_i = 32'hDEAD_BEEF;
    step;
    imem_rvalid_i = 0;
    #1;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL stale_valid: got %h expected 0", instr_valid_o); end
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL redir_req: got %h expected 1", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h8000_0100) begin errors++; $display("FAIL redir_addr: got %h expected 80000100", imem_addr_o); end
  endtask

  task automatic test_redirect_rvalid;
    imem_gnt_i = 1;
    step;
    imem_gnt_i = 0;
    redirect_i = 1;
    redirect_pc_i = 32'h0000_2003;
    imem_rvalid_i = 1;
    imem_rdata_i = 32'h1234;
    step;
    redirect_i = 0;
    imem_rvalid_i = 0;
    #1;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rv_valid: got %h expected 0", instr_valid_o); end
    checks++; if (instr_o !== 32'h13) begin errors++; $display("FAIL rv_instr: got %h expected 00000013", instr_o); end
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL rv_req: got %h expected 1", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h2000) begin errors++; $display("FAIL rv_addr: got %h expected 00002000", imem_addr_o); end
  endtask

  task automatic test_redirect_grant;
    imem_gnt_i = 1;
    redirect_i = 1;
    redirect_pc_i = 32'h3000;
    step;
    imem_gnt_i = 0;
    redirect_i = 0;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rg_req: got %h expected 0", imem_req_o); end
    imem_rvalid_i = 1;
    step;
    imem_rvalid_i = 0;
    #1;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rg_valid: got %h expected 0", instr_valid_o); end
    checks++; if (imem_addr_o !== 32'h3000) begin errors++; $display("FAIL rg_addr: got %h expected 00003000", imem_addr_o); end
  endtask

  task automatic test_redirect_req;
    redirect_i = 1;
    redirect_pc_i = 32'h4000;
    step;
    redirect_i = 0;
    #1;
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL rr_req: got %h expected 1", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h4000) begin errors++; $display("FAIL rr_addr: got %h expected 00004000", imem_addr_o); end
  endtask

  task automatic test_wrap;
    redirect_i = 1;
    redirect_pc_i = 32'hFFFF_FFFC;
    step;
    redirect_i = 0;
    fetch_one(32'h55);
    #1;
    checks++; if (instr_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h expected fffffffc", instr_pc_o); end
    checks++; if (instr_o !== 32'h55) begin errors++; $display("FAIL wrap_instr: got %h expected 00000055", instr_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 00000000", imem_addr_o); end
  endtask

  task automatic test_back_to_back;
    imem_gnt_i = 1;
    step;
    imem_gnt_i = 0;
    imem_rvalid_i = 1;
    imem_rdata_i = 32'h77;
    instr_ready_i = 1;
    step;
    imem_rvalid_i = 0;
    instr_ready_i = 0;
    #1;
    checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %h expected 1", instr_valid_o); end
    checks++; if (instr_o !== 32'h77) begin errors++; $display("FAIL b2b_instr: got %h expected 00000077", instr_o); end
    checks++; if (instr_pc_o !== 32'h0) begin errors++; $display("FAIL b2b_pc: got %h expected 00000000", instr_pc_o); end
    instr_ready_i = 1;
    step;
    instr_ready_i = 0;
    #1;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL drain_valid: got %h expected 0", instr_valid_o); end
  endtask

  task automatic test_reset_mid;
    fetch_one(32'h42);
    imem_gnt_i = 1;
    step;
    imem_gnt_i = 0;
    rst_n = 0;
    imem_rvalid_i = 1;
    imem_rdata_i = 32'h99;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %h expected 0", imem_req_o); end
    checks++; if (imem_addr_o !== BOOT) begin errors++; $display("FAIL mid_rst_addr: got %h expected %h", imem_addr_o, BOOT); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %h expected 0", instr_valid_o); end
    step;
    rst_n = 1;
    imem_rvalid_i = 0;
    #1;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %h expected 0", instr_valid_o); end
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL post_rst_req: got %h expected 1", imem_req_o); end
    checks++; if (imem_addr_o !== BOOT) begin errors++; $display("FAIL post_rst_addr: got %h expected %h", imem_addr_o, BOOT); end
    imem_rvalid_i = 1;
    step;
    imem_rvalid_i = 0;
    #1;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL late_rvalid: got %h expected 0", instr_valid_o); end
    checks++; if (imem_addr_o !== BOOT) begin errors++; $display("FAIL late_addr: got %h expected %h", imem_addr_o, BOOT); end
  endtask

  initial begin
    test_reset;
    test_first_fetch;
    test_fill;
    test_redirect_wait;
    test_redirect_rvalid;
    test_redirect_grant;
    test_redirect_req;
    test_wrap;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
